// File: rtl/sd_cic_decimator.sv
// Sigma-delta CIC decimator: 1-bit bitstream in, signed PCM samples out.
// Optional +6 dB saturating output stage when SD_CIC_GAIN2_EN is defined.
module sd_cic_decimator #(
   parameter int DATA_WIDTH = 16,
   parameter int ORDER      = 3,
   parameter int DECIMATION = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   input  logic                  i_bit,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data
);

   localparam int L = $clog2(DECIMATION);
   localparam int W = ORDER * L + 2;

`ifdef SD_CIC_GAIN2_EN
   localparam int USED = DATA_WIDTH + 1;
`else
   localparam int USED = DATA_WIDTH;
`endif

   if (DECIMATION < 2 || DECIMATION > 1024 || (1 << L) != DECIMATION) begin : g_bad_dec
      $error("DECIMATION must be a power of two in 2..1024");
   end
   if (ORDER < 1 || ORDER > 5) begin : g_bad_order
      $error("ORDER must be in 1..5");
   end
   if (W < USED) begin : g_bad_width
      $error("accumulator width too small for DATA_WIDTH");
   end

   logic [W-1:0]     din;
   logic [W-1:0]     integ [ORDER];
   logic [L-1:0]     cnt;
   logic             tick;
   logic [ORDER+1:0] en;
   logic [W-1:0]     cmb [ORDER+1];
   logic [W-1:0]     dly [ORDER];
   logic [W-1:0]     comb_out;

   assign din  = i_bit ? W'(1) : {W{1'b1}};
   assign tick = i_valid && (cnt == L'(DECIMATION - 1));

   // Counter wraps naturally because DECIMATION is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         for (int k = 0; k < ORDER; k++) integ[k] <= '0;
      end else if (i_valid) begin
         cnt      <= cnt + L'(1);
         integ[0] <= integ[0] + din;
         for (int k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
      end
   end

   // Each comb stage has its own enable so back-to-back blocks never collide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en <= '0;
         for (int j = 0; j <= ORDER; j++) cmb[j] <= '0;
         for (int j = 0; j < ORDER; j++) dly[j] <= '0;
      end else begin
         en <= {en[ORDER:0], tick};
         if (en[0]) cmb[0] <= integ[ORDER-1];
         for (int j = 1; j <= ORDER; j++) begin
            if (en[j]) begin
               cmb[j]   <= cmb[j-1] - dly[j-1];
               dly[j-1] <= cmb[j-1];
            end
         end
      end
   end

   assign o_valid  = en[ORDER+1];
   assign comb_out = cmb[ORDER];

`ifdef SD_CIC_GAIN2_EN
   localparam logic [DATA_WIDTH-1:0] PMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] NMAX = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] NMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [DATA_WIDTH-1:0] slice;

   assign slice = comb_out[W-2 -: DATA_WIDTH];

   always_comb begin
      o_data = slice;
      if (comb_out[W-1] != comb_out[W-2]) begin
         o_data = comb_out[W-1] ? NMAX : PMAX;
      end else if (slice == NMIN) begin
         o_data = NMAX;
      end
   end
`else
   assign o_data = comb_out[W-1 -: DATA_WIDTH];
`endif

   if (W > USED) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^comb_out[W-USED-1:0];
   end

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Directed bench for sd_cic_decimator: DC levels, settling, sparse input,
// mid-block reset and an LFSR stream against an untimed CIC model.
module tb_sd_cic_decimator;

   localparam int DW  = 16;
   localparam int ORD = 3;
   localparam int DEC = 64;
   localparam int W   = 20;

`ifdef SD_CIC_GAIN2_EN
   localparam int E_POS = 32767;
   localparam int E_NEG = -32767;
   localparam int E_S1  = 5208;
   localparam int E_S2  = 27048;
   localparam int E_MEAN = 16384;
`else
   localparam int E_POS = 16384;
   localparam int E_NEG = -16384;
   localparam int E_S1  = 2604;
   localparam int E_S2  = 13524;
   localparam int E_MEAN = 8192;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_valid = 1'b0;
   logic          i_bit = 1'b0;
   logic          o_valid;
   logic [DW-1:0] o_data;

   sd_cic_decimator #(
      .DATA_WIDTH(DW),
      .ORDER(ORD),
      .DECIMATION(DEC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .i_valid(i_valid),
      .i_bit(i_bit),
      .o_valid(o_valid),
      .o_data(o_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int outs[$];
   int out_cyc[$];
   always @(negedge clk) begin
      if (o_valid) begin
         outs.push_back(int'($signed(o_data)));
         out_cyc.push_back(cyc);
      end
   end

   int n_chk = 0;
   int n_fail = 0;
   int t_first = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   logic [15:0]  lfsr;
   logic [W-1:0] mi [ORD];
   logic [W-1:0] md [ORD];
   int           mcnt;
   int           mexp[$];

   function automatic int scale(input logic [W-1:0] v);
      logic [DW-1:0] s;
`ifdef SD_CIC_GAIN2_EN
      s = v[W-2 -: DW];
      if (v[W-1] != v[W-2]) return v[W-1] ? -32767 : 32767;
      if (int'($signed(s)) == -32768) return -32767;
      return int'($signed(s));
`else
      s = v[W-1 -: DW];
      return int'($signed(s));
`endif
   endfunction

   task automatic model_reset();
      for (int k = 0; k < ORD; k++) begin
         mi[k] = '0;
         md[k] = '0;
      end
      mcnt = 0;
      mexp.delete();
   endtask

   task automatic model_step(input logic b);
      logic [W-1:0] v;
      logic [W-1:0] y;
      for (int k = ORD - 1; k >= 1; k--) mi[k] = mi[k] + mi[k-1];
      mi[0] = mi[0] + (b ? W'(1) : {W{1'b1}});
      mcnt++;
      if (mcnt == DEC) begin
         mcnt = 0;
         v = mi[ORD-1];
         for (int j = 0; j < ORD; j++) begin
            y     = v - md[j];
            md[j] = v;
            v     = y;
         end
         mexp.push_back(scale(v));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      i_valid = 1'b0;
      i_bit = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      outs.delete();
      out_cyc.delete();
      model_reset();
   endtask

   // mode: 0 = -1, 1 = +1, 2 = alternating, 3 = LFSR density 0.75
   task automatic feed(input int n, input int mode, input int gap);
      logic b;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) t_first = cyc;
         case (mode)
            0: b = 1'b0;
            1: b = 1'b1;
            2: b = (i % 2 == 0);
            default: begin
               lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
               b = lfsr[0] | lfsr[1];
            end
         endcase
         i_valid = 1'b1;
         i_bit = b;
         model_step(b);
         for (int g = 1; g < gap; g++) begin
            @(negedge clk);
            i_valid = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         i_valid = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int    sum;
      int    n;
      string tag;

      // Reset state
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_valid", int'(o_valid), 0);
      check("rst_data", int'($signed(o_data)), 0);
      do_reset();

      // Dense +1
      feed(DEC * 6, 1, 1);
      idle(8);
      check("pos_count", outs.size(), 6);
      if (outs.size() == 6) begin
         check("pos_latency", out_cyc[0] - t_first, 68);
         check("pos_settle1", outs[0], E_S1);
         check("pos_settle2", outs[1], E_S2);
         for (int k = 3; k < 6; k++) check($sformatf("pos_out%0d", k + 1), outs[k], E_POS);
         for (int k = 1; k < 6; k++) check($sformatf("pos_period%0d", k), out_cyc[k] - out_cyc[k-1], DEC);
      end

      // Dense -1
      do_reset();
      feed(DEC * 6, 0, 1);
      idle(8);
      check("neg_count", outs.size(), 6);
      if (outs.size() == 6)
         for (int k = 3; k < 6; k++) check($sformatf("neg_out%0d", k + 1), outs[k], E_NEG);

      // Alternating
      do_reset();
      feed(DEC * 6, 2, 1);
      idle(8);
      check("alt_count", outs.size(), 6);
      if (outs.size() == 6)
         for (int k = 3; k < 6; k++) check($sformatf("alt_out%0d", k + 1), outs[k], 0);

      // Sparse: one accepted input every 16 cycles
      do_reset();
      feed(DEC * 5, 1, 16);
      idle(8);
      check("sparse_count", outs.size(), 5);
      if (outs.size() == 5) begin
         check("sparse_settle1", outs[0], E_S1);
         check("sparse_settle2", outs[1], E_S2);
         check("sparse_out4", outs[3], E_POS);
         check("sparse_out5", outs[4], E_POS);
         for (int k = 1; k < 5; k++) check($sformatf("sparse_period%0d", k), out_cyc[k] - out_cyc[k-1], DEC * 16);
      end
      feed(DEC - 1, 1, 16);
      idle(8);
      check("sparse_partial_block", outs.size(), 5);

      // Reset pulse 40 inputs into block 3
      do_reset();
      feed(DEC * 2 + 40, 1, 1);
      check("mid_pre_count", outs.size(), 2);
      check("mid_pre_data", int'($signed(o_data)), E_S2);
      @(negedge clk);
      rst = 1'b0;
      i_valid = 1'b0;
      #1;
      check("mid_async_valid", int'(o_valid), 0);
      check("mid_async_data", int'($signed(o_data)), 0);
      @(negedge clk);
      rst = 1'b1;
      outs.delete();
      out_cyc.delete();
      feed(DEC * 2, 1, 1);
      idle(8);
      check("mid_post_count", outs.size(), 2);
      if (outs.size() == 2) begin
         check("mid_post_latency", out_cyc[0] - t_first, 68);
         check("mid_post_settle1", outs[0], E_S1);
         check("mid_post_settle2", outs[1], E_S2);
      end

      // LFSR stream against the model
      do_reset();
      lfsr = 16'hACE1;
      feed(DEC * 200, 3, 1);
      idle(8);
      check("rand_count", outs.size(), 200);
      check("rand_model_count", mexp.size(), 200);
      n = (outs.size() < mexp.size()) ? outs.size() : mexp.size();
      for (int k = 0; k < n; k++) begin
         tag = $sformatf("rand_out%0d", k);
         check(tag, outs[k], mexp[k]);
      end
      sum = 0;
      for (int k = 3; k < outs.size(); k++) sum += outs[k];
      if (outs.size() > 3) begin
         sum = sum / (outs.size() - 3);
         check("rand_mean_in_range", int'(sum > E_MEAN - 512 && sum < E_MEAN + 512), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
